// File: rtl/cpu_press_ctrl_if.sv
// Signal bundle between the tick/LFSR source, the computer-player controller
// and the playfield logic that consumes the right-hand press.
interface cpu_press_ctrl_if #(
    parameter int DIFF_W = 9,
    parameter int CNT_W  = 8
);
    logic              enable;
    logic              round_over;
    logic              tick;
    logic [9:0]        lfsr_q;
    logic [DIFF_W-1:0] difficulty;
    logic              cpu_press;
    logic [1:0]        state;
    logic [CNT_W-1:0]  press_count;

    // Game side: drives qualifiers, sample strobe and threshold; sees the press.
    modport master (
        output enable,
        output round_over,
        output tick,
        output lfsr_q,
        output difficulty,
        input  cpu_press,
        input  state,
        input  press_count
    );

    // Controller side.
    modport slave (
        input  enable,
        input  round_over,
        input  tick,
        input  lfsr_q,
        input  difficulty,
        output cpu_press,
        output state,
        output press_count
    );
endinterface

// File: rtl/cpu_press_ctrl.sv
// Computer-player controller for the tug-of-war game. On each game-rate tick
// the LFSR sample is compared against the difficulty threshold; a hit yields
// a one-cycle registered press followed by a tick-counted cooldown.
module cpu_press_ctrl #(
    parameter int DIFF_W         = 9,
    parameter int COOLDOWN_TICKS = 3,
    parameter int CNT_W          = 8
) (
    input  logic             clk,
    input  logic             reset,
    cpu_press_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        ARMED    = 2'b01,
        PRESS    = 2'b10,
        COOLDOWN = 2'b11
    } state_t;

    localparam logic [7:0]       COOL_LOAD = 8'(COOLDOWN_TICKS);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    // A sample hits when strictly below the zero-extended threshold. The
    // all-ones value is the XNOR LFSR lock-up state and is never a hit, so a
    // stuck LFSR cannot make the computer press endlessly.
    function automatic logic is_hit(input logic [9:0]        sample,
                                    input logic [DIFF_W-1:0] thresh);
        logic [9:0] thresh_ext;
        thresh_ext = 10'(thresh);
        return (sample != 10'h3FF) && (sample < thresh_ext);
    endfunction

    state_t           state_r;
    state_t           state_nxt_s;
    logic [7:0]       cool_r;
    logic [7:0]       cool_nxt_s;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_nxt_s;
    logic             cpu_press_r;
    logic             hit_s;
    logic             press_fire_s;

    assign hit_s = is_hit(bus.lfsr_q, bus.difficulty);

    // Next-state and cooldown-counter logic; abort conditions override the FSM.
    always_comb begin
        state_nxt_s = state_r;
        cool_nxt_s  = cool_r;
        if (bus.round_over || !bus.enable) begin
            state_nxt_s = IDLE;
            cool_nxt_s  = 8'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    state_nxt_s = ARMED;
                end
                ARMED: begin
                    if (bus.tick && hit_s) begin
                        state_nxt_s = PRESS;
                    end else begin
                        state_nxt_s = ARMED;
                    end
                end
                PRESS: begin
                    // A tick arriving here is deliberately ignored.
                    if (COOL_LOAD == 8'd0) begin
                        state_nxt_s = ARMED;
                        cool_nxt_s  = 8'd0;
                    end else begin
                        state_nxt_s = COOLDOWN;
                        cool_nxt_s  = COOL_LOAD;
                    end
                end
                COOLDOWN: begin
                    if (bus.tick) begin
                        // <= 1 rather than == 1 so a zero count can never trap us here.
                        if (cool_r <= 8'd1) begin
                            state_nxt_s = ARMED;
                            cool_nxt_s  = 8'd0;
                        end else begin
                            cool_nxt_s  = cool_r - 8'd1;
                        end
                    end else begin
                        cool_nxt_s = cool_r;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                    cool_nxt_s  = 8'd0;
                end
            endcase
        end
    end

    // The press is issued on the edge that enters PRESS; the count moves with it.
    always_comb begin
        press_fire_s = (state_nxt_s == PRESS);
        if (press_fire_s && (count_r != CNT_MAX)) begin
            count_nxt_s = count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_nxt_s = count_r;
        end
    end

    // State, cooldown counter, statistics and press pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            cool_r      <= 8'd0;
            count_r     <= {CNT_W{1'b0}};
            cpu_press_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cool_r      <= cool_nxt_s;
            count_r     <= count_nxt_s;
            cpu_press_r <= press_fire_s;
        end
    end

    assign bus.cpu_press   = cpu_press_r;
    assign bus.state       = state_r;
    assign bus.press_count = count_r;

endmodule
